store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Write-posting buffer between the processor datapath (store/load issue) and the word-addressed data memory.
- Accepts stores in one cycle, queues them, and drains them to memory one per cycle whenever the shared memory address port is free.
- Loads always take the memory port. A load returns the youngest buffered store to its address, otherwise the memory read data.
- Lets stores retire without contending with loads for the single memory port.

Parameters:
- DEPTH, 4, number of buffer entries (power of two, >=2)
- AW, 32, address width (word address, passed unmodified to memory)
- DW, 32, data width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cpu_we  in  1  store request this cycle
- cpu_re  in  1  load request this cycle
- cpu_addr  in  AW  store/load word address
- cpu_wd  in  DW  store data
- cpu_rd  out  DW  load data (combinational)
- cpu_stall  out  1  store not accepted; hold the request
- hold  in  1  suppress draining (debug/test)
- mem_we  out  1  memory write enable
- mem_a  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  memory read data (combinational from mem_a)
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count==0

Behaviour:
- Storage: circular FIFO of {addr,data} entries, head/tail pointers, count register; wrap at DEPTH.
- Reset (async, rst_n=0): head=tail=0, count=0, all valid bits cleared.
  - Entries pending at reset are discarded, not written to memory.
  - Outputs during reset: mem_we=0, empty=1, count=0, cpu_stall=cpu_we&0 (i.e. 0).
- Enqueue:
  - Condition: cpu_we=1 and count<DEPTH.
  - At the clock edge, write {cpu_addr,cpu_wd} at tail; tail+=1.
- Stall: cpu_stall = cpu_we & (count==DEPTH), combinational.
  - A store arriving when full is not accepted, even if a drain occurs the same cycle.
  - The request is accepted in the next cycle.
- Drain:
  - drain = !empty & !cpu_re & !hold.
  - mem_we=drain; mem_wd=head data. Memory writes at the edge, head+=1.
  - Throughput: 1 entry/cycle.
- Address mux: mem_a = cpu_re ? cpu_addr : head addr (head addr when empty; don't-care since mem_we=0).
- Latency: a store accepted at edge N is earliest written to memory at edge N+1. No same-cycle bypass to memory.
- Count: +1 on enqueue, -1 on drain, unchanged if both or neither.
- Load forwarding (combinational):
  - Compare cpu_addr with every valid entry; full AW-bit compare.
  - On hit, cpu_rd = data of the youngest matching entry (closest to tail); on miss, cpu_rd = mem_rd.
  - A store presented in the same cycle as the load is NOT visible to that load.
- Simultaneous cpu_we & cpu_re: legal. The load is served per the forwarding rules, the store is enqueued per the enqueue rules, and there is no drain that cycle.
- Ordering: memory writes occur strictly in acceptance order. Duplicate addresses are not coalesced.
- cpu_rd when cpu_re=0: don't-care (drive mem_rd-path value).

Decomposition:
- Package store_buffer_pkg:
  - DEPTH/AW/DW defaults
  - entry typedef {addr, data}
  - pointer-width constant $clog2(DEPTH)
- Sub-module store_buffer_fwd: combinational youngest-match search.
  - Inputs: entry array, valid vector, head, load address.
  - Outputs: hit, data.
- The top holds FIFO registers, pointers, count and port muxing.

Test Plan:
- Reset, then store A=8 WD=32'hDEAD with idle following cycle -> next cycle mem_we=1, mem_a=8, mem_wd=32'hDEAD; after that edge empty=1, count=0.
- Store A=3 WD=32'h11, store A=3 WD=32'h22 with hold=1, then load A=3 -> cpu_rd=32'h22, mem_we=0, mem_a=3; release hold -> memory receives 32'h11 then 32'h22 on consecutive edges.
- Buffer holds A=5 WD=32'h99 (hold=1), memory word 1 = 7; load A=1 -> cpu_rd=7 (miss passes mem_rd), count stays 1.
- hold=1, stores to A=0..3 -> count=4; fifth store A=4 -> cpu_stall=1, not accepted; hold=0 -> drains A=0,1,2,3 in order, stall clears after first drain, A=4 accepted next cycle.
- count=3 with hold=1; pulse rst_n=0 mid-cycle (async) -> count=0, empty=1, mem_we=0 immediately; after release, no writes occur.
- Empty buffer, memory word 2 = 4; same-cycle store A=2 WD=32'h55 and load A=2 -> cpu_rd=4, count=1; next idle cycle mem_we=1, mem_a=2, mem_wd=32'h55.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared defaults and types for the store buffer.
//   SB_DEPTH / SB_AW / SB_DW : default entry count, word-address width, data width
//   SB_PW                    : pointer width for the default depth
//   entry_t                  : one buffered store {addr, data} at the default widths
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int SB_PW    = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd: combinational youngest-match search over the buffer.
//   ent_addr/ent_data : entry storage, indexed by physical slot
//   valid             : per-slot occupied flag
//   head              : slot of the oldest entry
//   load_addr         : address being loaded
//   hit               : some valid entry matches load_addr
//   data              : data of the youngest matching entry (0 when no hit)
module store_buffer_fwd #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0]    ent_addr [DEPTH],
  input  logic [DW-1:0]    ent_data [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    head,
  input  logic [AW-1:0]    load_addr,
  output logic             hit,
  output logic [DW-1:0]    data
);

  logic [PW-1:0] idx;

  // Walk slots from oldest (head) to youngest; a later match overrides an
  // earlier one, so the surviving value belongs to the entry nearest tail.
  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && (ent_addr[idx] == load_addr)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: write-posting buffer between CPU store/load issue and a
// single-port word-addressed data memory.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cpu_we/cpu_re       : store / load request this cycle
//   cpu_addr, cpu_wd    : word address, store data
//   cpu_rd              : load data (forwarded from buffer or from memory)
//   cpu_stall           : store refused because the buffer is full
//   hold                : suppress draining
//   mem_we/mem_a/mem_wd : memory write enable, address, write data
//   mem_rd              : memory read data, combinational from mem_a
//   count, empty        : occupancy
//
// Handshake: a store is accepted at the rising edge of any cycle in which
// cpu_we=1 and cpu_stall=0; when cpu_stall=1 the requester holds cpu_addr and
// cpu_wd stable and retries. Loads are never stalled and own the memory port
// for their cycle.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [DW-1:0]          cpu_wd,
  output logic [DW-1:0]          cpu_rd,
  output logic                   cpu_stall,
  input  logic                   hold,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_a,
  output logic [DW-1:0]          mem_wd,
  input  logic [DW-1:0]          mem_rd,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      cnt;

  logic full;
  logic is_empty;
  logic enq;
  logic drain;
  logic fwd_hit;
  logic [DW-1:0] fwd_data;

  assign full     = (cnt == CNT_FULL);
  assign is_empty = (cnt == '0);

  // Acceptance looks only at the registered count: a drain in the same cycle
  // does not free room for a store until the following cycle.
  assign enq   = cpu_we & ~full;
  assign drain = ~is_empty & ~cpu_re & ~hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      valid <= '0;
    end else begin
      // enq and drain never touch the same slot: tail==head only when empty
      // (no drain) or full (no enqueue).
      if (enq) begin
        tail        <= tail + 1'b1;
        valid[tail] <= 1'b1;
      end
      if (drain) begin
        head        <= head + 1'b1;
        valid[head] <= 1'b0;
      end
      case ({enq, drain})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= cpu_addr;
      ent_data[tail] <= cpu_wd;
    end
  end

  store_buffer_fwd #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .PW    (PW)
  ) u_fwd (
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .valid     (valid),
    .head      (head),
    .load_addr (cpu_addr),
    .hit       (fwd_hit),
    .data      (fwd_data)
  );

  // The buffer contents are registered, so a store presented this cycle is
  // not yet visible to a load in the same cycle.
  assign cpu_rd    = (cpu_re && fwd_hit) ? fwd_data : mem_rd;
  assign cpu_stall = cpu_we & full;
  assign mem_we    = drain;
  assign mem_a     = cpu_re ? cpu_addr : ent_addr[head];
  assign mem_wd    = ent_data[head];
  assign count     = cnt;
  assign empty     = is_empty;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          cpu_we;
  logic          cpu_re;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wd;
  logic [DW-1:0] cpu_rd;
  logic          cpu_stall;
  logic          hold;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic [2:0]    count;
  logic          empty;

  int checks;
  int failures;

  // memory model: 16 words, preload port used only while the DUT is not writing
  logic [DW-1:0] mem [16];
  logic          pre_we;
  logic [3:0]    pre_a;
  logic [DW-1:0] pre_d;
  logic [AW+DW-1:0] wlog[$];
  logic [AW+DW-1:0] exp_q[$];

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wd    (cpu_wd),
    .cpu_rd    (cpu_rd),
    .cpu_stall (cpu_stall),
    .hold      (hold),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .count     (count),
    .empty     (empty)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[3:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[3:0]] <= mem_wd;
      wlog.push_back({mem_a, mem_wd});
    end else if (pre_we) begin
      mem[pre_a] <= pre_d;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are sampled at the falling edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wd = '0; hold = 1'b0;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = a; cpu_wd = d;
  endtask

  task automatic load(input logic [AW-1:0] a);
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = a;
  endtask

  task automatic preload(input logic [3:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    cycle();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); cpu_we = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    #4;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
    cycle(); cycle();
    idle(); rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    wlog.delete(); exp_q.delete();
    store(32'd8, 32'hDEAD); #4;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL basic_no_bypass got=%b exp=0", mem_we); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL basic_stall got=%b exp=0", cpu_stall); end
    cycle(); idle(); #4;
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count); end
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL basic_mem_we got=%b exp=1", mem_we); end
    checks++; if (mem_a !== 32'd8) begin failures++; $display("FAIL basic_mem_a got=%h exp=8", mem_a); end
    checks++; if (mem_wd !== 32'hDEAD) begin failures++; $display("FAIL basic_mem_wd got=%h exp=dead", mem_wd); end
    cycle(); #4;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", empty); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL basic_count_after got=%0d exp=0", count); end
    checks++; if (mem[8] !== 32'hDEAD) begin failures++; $display("FAIL basic_mem8 got=%h exp=dead", mem[8]); end
    exp_q.push_back({32'd8, 32'hDEAD});
    checks++;
    if (wlog.size() != exp_q.size()) begin failures++; $display("FAIL basic_log_size got=%0d exp=%0d", wlog.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (wlog[i] !== exp_q[i]) begin failures++; $display("FAIL basic_log[%0d] got=%h exp=%h", i, wlog[i], exp_q[i]); end
    end
    cycle();
  endtask

  task automatic test_forward_youngest();
    wlog.delete(); exp_q.delete();
    hold = 1'b1; store(32'd3, 32'h11);
    cycle(); store(32'd3, 32'h22);
    cycle(); load(32'd3); #4;
    checks++; if (cpu_rd !== 32'h22) begin failures++; $display("FAIL fwd_young_rd got=%h exp=22", cpu_rd); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL fwd_young_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_a !== 32'd3) begin failures++; $display("FAIL fwd_young_mem_a got=%h exp=3", mem_a); end
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL fwd_young_count got=%0d exp=2", count); end
    cycle(); idle(); #4;
    checks++; if (mem_we !== 1'b1 || mem_a !== 32'd3 || mem_wd !== 32'h11) begin failures++; $display("FAIL fwd_young_drain1 got we=%b a=%h wd=%h exp we=1 a=3 wd=11", mem_we, mem_a, mem_wd); end
    cycle(); #4;
    checks++; if (mem_we !== 1'b1 || mem_a !== 32'd3 || mem_wd !== 32'h22) begin failures++; $display("FAIL fwd_young_drain2 got we=%b a=%h wd=%h exp we=1 a=3 wd=22", mem_we, mem_a, mem_wd); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL fwd_young_count1 got=%0d exp=1", count); end
    cycle(); #4;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fwd_young_empty got=%b exp=1", empty); end
    exp_q.push_back({32'd3, 32'h11}); exp_q.push_back({32'd3, 32'h22});
    checks++;
    if (wlog.size() != exp_q.size()) begin failures++; $display("FAIL fwd_young_log_size got=%0d exp=%0d", wlog.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (wlog[i] !== exp_q[i]) begin failures++; $display("FAIL fwd_young_log[%0d] got=%h exp=%h", i, wlog[i], exp_q[i]); end
    end
    cycle();
  endtask

  task automatic test_load_miss();
    wlog.delete(); exp_q.delete();
    preload(4'd1, 32'd7);
    hold = 1'b1; store(32'd5, 32'h99);
    cycle(); load(32'd1); #4;
    checks++; if (cpu_rd !== 32'd7) begin failures++; $display("FAIL miss_rd got=%h exp=7", cpu_rd); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL miss_count got=%0d exp=1", count); end
    cycle(); load(32'd5); #4;
    checks++; if (cpu_rd !== 32'h99) begin failures++; $display("FAIL miss_hit_rd got=%h exp=99", cpu_rd); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL miss_count_kept got=%0d exp=1", count); end
    cycle(); idle(); #4;
    checks++; if (mem_we !== 1'b1 || mem_a !== 32'd5 || mem_wd !== 32'h99) begin failures++; $display("FAIL miss_drain got we=%b a=%h wd=%h exp we=1 a=5 wd=99", mem_we, mem_a, mem_wd); end
    cycle(); #4;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL miss_empty got=%b exp=1", empty); end
    cycle();
  endtask

  task automatic test_full_stall();
    int k;
    wlog.delete(); exp_q.delete();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      store(AW'(i), 32'hA0 + DW'(i));
      exp_q.push_back({AW'(i), 32'hA0 + DW'(i)});
      cycle();
    end
    store(32'd4, 32'hA4); #4;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL full_stall got=%b exp=1", cpu_stall); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL full_hold_mem_we got=%b exp=0", mem_we); end
    cycle(); hold = 1'b0; #4;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_not_accepted got=%0d exp=4", count); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL full_stall_drain got=%b exp=1", cpu_stall); end
    checks++; if (mem_we !== 1'b1 || mem_a !== 32'd0 || mem_wd !== 32'hA0) begin failures++; $display("FAIL full_drain0 got we=%b a=%h wd=%h exp we=1 a=0 wd=a0", mem_we, mem_a, mem_wd); end
    cycle(); #4;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_count3 got=%0d exp=3", count); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL full_stall_clear got=%b exp=0", cpu_stall); end
    checks++; if (mem_a !== 32'd1) begin failures++; $display("FAIL full_drain1_a got=%h exp=1", mem_a); end
    cycle(); idle(); #4;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_enq_and_drain got=%0d exp=3", count); end
    exp_q.push_back({32'd4, 32'hA4});
    k = 0;
    while (empty !== 1'b1 && k < 10) begin cycle(); #4; k++; end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drain_timeout got empty=%b exp=1", empty); end
    checks++;
    if (wlog.size() != exp_q.size()) begin failures++; $display("FAIL full_log_size got=%0d exp=%0d", wlog.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (wlog[i] !== exp_q[i]) begin failures++; $display("FAIL full_log[%0d] got=%h exp=%h", i, wlog[i], exp_q[i]); end
    end
    cycle();
  endtask

  task automatic test_async_reset();
    wlog.delete();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      store(32'd10 + AW'(i), 32'hB0 + DW'(i));
      cycle();
    end
    cpu_we = 1'b0; #2;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL areset_pre_count got=%0d exp=3", count); end
    hold = 1'b0; store(32'd7, 32'h77); rst_n = 1'b0; #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL areset_empty got=%b exp=1", empty); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL areset_mem_we got=%b exp=0", mem_we); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL areset_stall got=%b exp=0", cpu_stall); end
    cycle(); #3; idle(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    #4;
    checks++; if (wlog.size() != 0) begin failures++; $display("FAIL areset_no_writes got=%0d exp=0", wlog.size()); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL areset_count_after got=%0d exp=0", count); end
    cycle();
  endtask

  task automatic test_same_cycle();
    wlog.delete();
    preload(4'd2, 32'd4);
    cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 32'd2; cpu_wd = 32'h55; #4;
    checks++; if (cpu_rd !== 32'd4) begin failures++; $display("FAIL same_rd got=%h exp=4", cpu_rd); end
    checks++; if (mem_we !== 1'b0 || mem_a !== 32'd2) begin failures++; $display("FAIL same_port got we=%b a=%h exp we=0 a=2", mem_we, mem_a); end
    cycle(); idle(); #4;
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL same_count got=%0d exp=1", count); end
    checks++; if (mem_we !== 1'b1 || mem_a !== 32'd2 || mem_wd !== 32'h55) begin failures++; $display("FAIL same_drain got we=%b a=%h wd=%h exp we=1 a=2 wd=55", mem_we, mem_a, mem_wd); end
    cycle(); #4;
    checks++; if (mem[2] !== 32'h55) begin failures++; $display("FAIL same_mem2 got=%h exp=55", mem[2]); end
    cycle();
  endtask

  task automatic test_wrap_forward();
    int k;
    wlog.delete(); exp_q.delete();
    preload(4'd12, 32'hC);
    hold = 1'b1;
    store(32'd9, 32'd1);  cycle();
    store(32'd10, 32'd2); cycle();
    store(32'd11, 32'd3); cycle();
    store(32'd9, 32'd4);  cycle();
    exp_q.push_back({32'd9, 32'd1}); exp_q.push_back({32'd10, 32'd2});
    exp_q.push_back({32'd11, 32'd3}); exp_q.push_back({32'd9, 32'd4});
    load(32'd9); #4;
    checks++; if (cpu_rd !== 32'd4) begin failures++; $display("FAIL wrap_rd9 got=%h exp=4", cpu_rd); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", count); end
    cycle(); load(32'd10); #4;
    checks++; if (cpu_rd !== 32'd2) begin failures++; $display("FAIL wrap_rd10 got=%h exp=2", cpu_rd); end
    cycle(); load(32'd11); #4;
    checks++; if (cpu_rd !== 32'd3) begin failures++; $display("FAIL wrap_rd11 got=%h exp=3", cpu_rd); end
    cycle(); load(32'd12); #4;
    checks++; if (cpu_rd !== 32'hC) begin failures++; $display("FAIL wrap_rd12 got=%h exp=c", cpu_rd); end
    cycle(); idle();
    k = 0;
    #4;
    while (empty !== 1'b1 && k < 10) begin cycle(); #4; k++; end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_drain_timeout got empty=%b exp=1", empty); end
    checks++;
    if (wlog.size() != exp_q.size()) begin failures++; $display("FAIL wrap_log_size got=%0d exp=%0d", wlog.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (wlog[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_log[%0d] got=%h exp=%h", i, wlog[i], exp_q[i]); end
    end
    cycle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_forward_youngest();
    test_load_miss();
    test_full_stall();
    test_async_reset();
    test_same_cycle();
    test_wrap_forward();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
